sample_checker: RTL and testbench
=================================

// Module: sample_checker
// PURPOSE
//  Synthesizable checker downstream of the DUT in the file-driven test environment.
//  Buffers expected samples from the read side and compares them in order against
//  DUT output samples.
//  Keeps point, mismatch, unexpected and missing counts, and captures the first mismatch
//  for the write/log side.
// PARAMETERS
//  DATA_W         16   width of expected/actual samples
//  FIFO_DEPTH     16   expected-sample buffer depth; power of 2, >=2
//  CNT_W          32   width of every counter; all counters saturate at all-ones
//  DRAIN_TIMEOUT  64   cycles DRAIN waits for outstanding expected samples
//  TOL            0    absolute tolerance; used only with SAMPLE_CHK_TOL_EN
// PORTS
//  clk            in   1        single clock; all logic on posedge
//  rst            in   1        synchronous, active-high reset
//  start          in   1        pulse: clear results and begin a run
//  stop           in   1        pulse: end of test vector; begin drain
//  exp_valid      in   1        expected sample valid
//  exp_ready      out  1        expected sample accepted when exp_valid & exp_ready
//  exp_data       in   DATA_W   expected sample
//  act_valid      in   1        DUT output sample valid; no backpressure
//  act_data       in   DATA_W   DUT output sample
//  mismatch       out  1        1-cycle pulse, registered compare failure
//  busy           out  1        state is RUN or DRAIN
//  done           out  1        state is DONE; results stable
//  point_cnt      out  CNT_W    compared samples
//  mismatch_cnt   out  CNT_W    failed compares
//  unexpected_cnt out  CNT_W    act_valid with buffer empty
//  missing_cnt    out  CNT_W    expected samples left at drain timeout
//  first_valid    out  1        first-mismatch capture is valid
//  first_idx      out  CNT_W    point index (0-based) of first mismatch
//  first_exp      out  DATA_W   expected value at first mismatch
//  first_act      out  DATA_W   actual value at first mismatch
// BEHAVIOUR
//  Reset: state IDLE; buffer emptied; every output and counter 0. Also applies mid-run.
//  FSM: IDLE -start-> RUN. RUN -stop-> DRAIN.
//   DRAIN -(empty | timeout)-> DONE. DONE -start-> RUN.
//   start in RUN/DRAIN ignored; stop outside RUN ignored; start+stop same cycle in RUN: stop wins.
//  start accepted: all counters, first_* and the buffer are cleared in the same cycle.
//  exp_ready = (state==RUN) & !full. A pop does not free a slot in the same cycle;
//   full stays non-ready even while popping.
//  Compare: only in RUN/DRAIN, when act_valid. If the buffer is non-empty, pop the head
//   and compare against act_data. Otherwise unexpected_cnt++. No bypass: a sample pushed
//   in cycle N can be compared no earlier than N+1.
//  Latency: act_valid at cycle N -> mismatch, counters and first_* update at N+1.
//  point_cnt counts every compare. first_idx = point_cnt before the increment.
//  first_* written only while first_valid=0.
//  act_valid in IDLE/DONE: ignored, not counted.
//  DRAIN: timer counts from 0. At DRAIN_TIMEOUT with buffer not empty:
//   missing_cnt += occupancy, buffer flushed, go DONE.
//  Saturation: a counter at all-ones holds; the others keep counting.
// CONFIGURATION
//  SAMPLE_CHK_TOL_EN defined: mismatch when |act-exp| > TOL, unsigned DATA_W+1-bit diff.
//  SAMPLE_CHK_TOL_EN undefined: exact equality; TOL unused.
// STRUCTURE
//  Package sample_chk_pkg: state_e {IDLE,RUN,DRAIN,DONE}; clog2-based ptr width
//   function; power-of-2 depth check function.
//  Sub-module sample_fifo: synchronous FIFO (DATA_W x FIFO_DEPTH, push/pop/full/empty/
//   count/flush). Pointers one bit wider than the address for full/empty.
// TESTING
//  start; push 4 exp {1,2,3,4}; act {1,2,3,4} one per cycle; stop
//   -> point_cnt=4, mismatch_cnt=0, done=1.
//  exp {10,20,30}, act {10,21,30}
//   -> mismatch pulse 1 cycle after 2nd act; mismatch_cnt=1; first_idx=1, first_exp=20,
//   first_act=21.
//  Push 16 exp with no act -> exp_ready=0 after 16th;
//   17th exp_valid not accepted until one pop, then accepted the cycle after.
//  act_valid with buffer empty x3 -> unexpected_cnt=3, point_cnt=0.
//  5 exp, 2 act, stop -> DONE after 64 DRAIN cycles, missing_cnt=3.
//   rst mid-RUN -> all outputs 0, state IDLE.
//  SAMPLE_CHK_TOL_EN, TOL=2: exp 100, act {102,103} -> first passes, second mismatches.

Source files
------------

// File: rtl/sample_chk_pkg.sv
// sample_chk_pkg: shared state type and elaboration helpers for sample_checker
//  state_e  : checker FSM states
//  ptr_w    : address width for a buffer of the given depth
//  is_pow2  : legal buffer depth (power of two, at least 2)
package sample_chk_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction
   function automatic bit is_pow2(input int depth);
      return depth >= 2 && (depth & (depth - 1)) == 0;
   endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous DATA_W x DEPTH buffer of expected samples
//  clk, rst      : clock, synchronous active-high reset
//  push, din     : write when not full
//  pop, dout     : dout is the head; pop advances it when not empty
//  flush         : empties the buffer (wins over push/pop)
//  full, empty   : status; pointers carry one extra wrap bit
//  count         : current occupancy
module sample_fifo
   import sample_chk_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH = 16,
   localparam int AW = ptr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       count
);
   if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("sample_fifo: DEPTH must be a power of two >= 2");
   end
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end
   always_ff @(posedge clk)
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
   assign dout  = mem[rd_ptr[AW-1:0]];
   assign empty = wr_ptr == rd_ptr;
   assign full  = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
   assign count = wr_ptr - rd_ptr;
endmodule

// File: rtl/sample_checker.sv
// sample_checker: in-order compare of buffered expected samples against DUT output
//  clk, rst                 : clock, synchronous active-high reset
//  start, stop              : begin a run (clears results) / end vector, begin drain
//  exp_valid/ready/data     : expected-sample input with backpressure
//  act_valid/data           : DUT output samples, no backpressure
//  mismatch                 : registered one-cycle compare-failure pulse
//  busy, done               : RUN or DRAIN / DONE
//  point/mismatch/unexpected/missing_cnt : saturating result counters
//  first_valid/idx/exp/act  : capture of the first failing compare
//  Macro SAMPLE_CHK_TOL_EN: compare with absolute tolerance TOL instead of equality.
module sample_checker
   import sample_chk_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W = 32,
   parameter int DRAIN_TIMEOUT = 64,
   parameter int TOL = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              exp_valid,
   output logic              exp_ready,
   input  logic [DATA_W-1:0] exp_data,
   input  logic              act_valid,
   input  logic [DATA_W-1:0] act_data,
   output logic              mismatch,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  point_cnt,
   output logic [CNT_W-1:0]  mismatch_cnt,
   output logic [CNT_W-1:0]  unexpected_cnt,
   output logic [CNT_W-1:0]  missing_cnt,
   output logic              first_valid,
   output logic [CNT_W-1:0]  first_idx,
   output logic [DATA_W-1:0] first_exp,
   output logic [DATA_W-1:0] first_act
);
   localparam int AW = ptr_w(FIFO_DEPTH);
   localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
`ifdef SAMPLE_CHK_TOL_EN
   localparam int TOL_EFF = TOL;
`else
   localparam int TOL_EFF = 0 * TOL; // zero tolerance is exact equality
`endif
   state_e state, state_nxt;
   logic [DATA_W-1:0] head;
   logic full, empty, start_acc, cmp, pop, unexp, timeout, miss;
   logic [AW:0] occ, left;
   logic [TW-1:0] timer;
   logic [DATA_W:0] diff;
   logic [CNT_W:0] miss_sum;
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return &v ? v : v + 1'b1;
   endfunction
   assign start_acc = start && (state == IDLE || state == DONE);
   assign cmp       = act_valid && busy;
   assign pop       = cmp && !empty;
   assign unexp     = cmp && empty;
   assign timeout   = state == DRAIN && !empty && timer == TW'(DRAIN_TIMEOUT - 1);
   assign diff      = act_data >= head ? {1'b0, act_data} - {1'b0, head} : {1'b0, head} - {1'b0, act_data};
   assign miss      = diff > (DATA_W+1)'(TOL_EFF);
   // a sample popped in the timeout cycle is compared, not counted missing
   assign left      = occ - {{AW{1'b0}}, pop};
   assign miss_sum  = {1'b0, missing_cnt} + (CNT_W+1)'(left);
   sample_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(exp_valid && exp_ready), .pop(pop),
      .flush(start_acc || timeout), .din(exp_data), .dout(head),
      .full(full), .empty(empty), .count(occ)
   );
   always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
   always_comb begin
      state_nxt = (state == IDLE || state == DONE) ? (start ? RUN : state)
                : state == RUN ? (stop ? DRAIN : RUN)
                : (empty || timeout) ? DONE : DRAIN;
   end
   always_comb begin
      busy      = state == RUN || state == DRAIN;
      done      = state == DONE;
      exp_ready = state == RUN && !full;
   end
   always_ff @(posedge clk) timer <= (rst || state != DRAIN) ? '0 : timer + 1'b1;
   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         mismatch       <= 1'b0;
         point_cnt      <= '0;
         mismatch_cnt   <= '0;
         unexpected_cnt <= '0;
         missing_cnt    <= '0;
         first_valid    <= 1'b0;
         first_idx      <= '0;
         first_exp      <= '0;
         first_act      <= '0;
      end else begin
         mismatch <= pop && miss;
         if (pop) point_cnt <= sat_inc(point_cnt);
         if (pop && miss) mismatch_cnt <= sat_inc(mismatch_cnt);
         if (pop && miss && !first_valid) begin
            first_valid <= 1'b1;
            first_idx   <= point_cnt;
            first_exp   <= head;
            first_act   <= act_data;
         end
         if (unexp) unexpected_cnt <= sat_inc(unexpected_cnt);
         if (timeout) missing_cnt <= miss_sum[CNT_W] ? '1 : miss_sum[CNT_W-1:0];
      end
   end
endmodule

// File: tb/tb_sample_checker.sv
// tb_sample_checker: vector table plus hand sequences for sample_checker
module tb_sample_checker;
   localparam int DW = 16;
   localparam int CW = 32;
   localparam int TO = 64;
   logic clk = 1'b0;
   logic rst, start, stop, exp_valid, exp_ready, act_valid, mismatch, busy, done, first_valid;
   logic [DW-1:0] exp_data, act_data, first_exp, first_act;
   logic [CW-1:0] point_cnt, mismatch_cnt, unexpected_cnt, missing_cnt, first_idx;
   int checks = 0;
   int errors = 0;
   int n;
   bit sb_q[$];
   typedef struct {
      logic          ev;
      logic [DW-1:0] ed;
      logic          av;
      logic [DW-1:0] ad;
      logic          mm;
   } vec_t;
   vec_t vecs[9];
   always #5 clk = ~clk;
   sample_checker #(.DATA_W(DW), .FIFO_DEPTH(16), .CNT_W(CW), .DRAIN_TIMEOUT(TO), .TOL(2)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
      .act_valid(act_valid), .act_data(act_data), .mismatch(mismatch),
      .busy(busy), .done(done), .point_cnt(point_cnt), .mismatch_cnt(mismatch_cnt),
      .unexpected_cnt(unexpected_cnt), .missing_cnt(missing_cnt),
      .first_valid(first_valid), .first_idx(first_idx),
      .first_exp(first_exp), .first_act(first_act)
   );
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic ev, input logic [DW-1:0] ed, input logic av,
                        input logic [DW-1:0] ad, input logic mm);
      exp_valid = ev;
      exp_data  = ed;
      act_valid = av;
      act_data  = ad;
      sb_q.push_back(av ? mm : 1'b0);
      tick();
      exp_valid = 1'b0;
      act_valid = 1'b0;
      chk("mismatch", {31'd0, mismatch}, {31'd0, sb_q.pop_front()});
   endtask
   task automatic pulse(input logic s, input logic p);
      start = s;
      stop  = p;
      tick();
      start = 1'b0;
      stop  = 1'b0;
   endtask
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 200) begin
         tick();
         cyc++;
      end
      chk("done_reached", {31'd0, done}, 32'd1);
   endtask
   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "timeout");
   end
   initial begin
      vecs[0] = '{1'b1, 16'd1,  1'b0, 16'd0,  1'b0};
      vecs[1] = '{1'b1, 16'd2,  1'b1, 16'd1,  1'b0};
      vecs[2] = '{1'b1, 16'd3,  1'b1, 16'd2,  1'b0};
      vecs[3] = '{1'b1, 16'd4,  1'b1, 16'd3,  1'b0};
      vecs[4] = '{1'b0, 16'd0,  1'b1, 16'd4,  1'b0};
      vecs[5] = '{1'b1, 16'd10, 1'b0, 16'd0,  1'b0};
      vecs[6] = '{1'b1, 16'd20, 1'b1, 16'd10, 1'b0};
      vecs[7] = '{1'b1, 16'd30, 1'b1, 16'd21, 1'b1};
      vecs[8] = '{1'b0, 16'd0,  1'b1, 16'd30, 1'b0};
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      exp_valid = 1'b0; exp_data = '0; act_valid = 1'b0; act_data = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_exp_ready", {31'd0, exp_ready}, 32'd0);
      chk("rst_point", point_cnt, 32'd0);
      chk("rst_first_valid", {31'd0, first_valid}, 32'd0);
      pulse(1'b0, 1'b1);
      chk("stop_idle_ignored", {31'd0, busy}, 32'd0);
      pulse(1'b1, 1'b0);
      chk("run_busy", {31'd0, busy}, 32'd1);
      chk("run_ready", {31'd0, exp_ready}, 32'd1);
      for (int i = 0; i < 5; i++) drive(vecs[i].ev, vecs[i].ed, vecs[i].av, vecs[i].ad, vecs[i].mm);
      pulse(1'b0, 1'b1);
      wait_done(n);
      chk("a_point", point_cnt, 32'd4);
      chk("a_mm_cnt", mismatch_cnt, 32'd0);
      chk("a_first_valid", {31'd0, first_valid}, 32'd0);
      drive(1'b0, 16'd0, 1'b1, 16'd7, 1'b0);
      chk("done_act_point", point_cnt, 32'd4);
      chk("done_act_unexp", unexpected_cnt, 32'd0);
      pulse(1'b1, 1'b0);
      chk("start_clears", point_cnt, 32'd0);
      for (int i = 5; i < 9; i++) drive(vecs[i].ev, vecs[i].ed, vecs[i].av, vecs[i].ad, vecs[i].mm);
      chk("b_mm_cnt", mismatch_cnt, 32'd1);
      chk("b_first_valid", {31'd0, first_valid}, 32'd1);
      chk("b_first_idx", first_idx, 32'd1);
      chk("b_first_exp", {16'd0, first_exp}, 32'd20);
      chk("b_first_act", {16'd0, first_act}, 32'd21);
      chk("b_point", point_cnt, 32'd3);
      pulse(1'b0, 1'b1);
      wait_done(n);
      pulse(1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         chk("ready_before_full", {31'd0, exp_ready}, 32'd1);
         drive(1'b1, 16'(100 + i), 1'b0, 16'd0, 1'b0);
      end
      chk("full_not_ready", {31'd0, exp_ready}, 32'd0);
      drive(1'b1, 16'd999, 1'b1, 16'd100, 1'b0);
      chk("ready_after_pop", {31'd0, exp_ready}, 32'd1);
      drive(1'b1, 16'd999, 1'b0, 16'd0, 1'b0);
      for (int i = 1; i < 16; i++) drive(1'b0, 16'd0, 1'b1, 16'(100 + i), 1'b0);
      drive(1'b0, 16'd0, 1'b1, 16'd999, 1'b0);
      chk("full_point", point_cnt, 32'd17);
      chk("full_mm_cnt", mismatch_cnt, 32'd0);
      drive(1'b0, 16'd0, 1'b1, 16'd5, 1'b0);
      chk("full_unexp", unexpected_cnt, 32'd1);
      pulse(1'b0, 1'b1);
      wait_done(n);
      pulse(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 16'd0, 1'b1, 16'(i), 1'b0);
      chk("unexp_cnt", unexpected_cnt, 32'd3);
      chk("unexp_point", point_cnt, 32'd0);
      pulse(1'b0, 1'b1);
      wait_done(n);
      pulse(1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) drive(1'b1, 16'(i), 1'b0, 16'd0, 1'b0);
      drive(1'b0, 16'd0, 1'b1, 16'd1, 1'b0);
      drive(1'b0, 16'd0, 1'b1, 16'd2, 1'b0);
      pulse(1'b0, 1'b1);
      wait_done(n);
      chk("drain_cycles", n, TO);
      chk("missing_cnt", missing_cnt, 32'd3);
      chk("missing_point", point_cnt, 32'd2);
      pulse(1'b1, 1'b0);
`ifdef SAMPLE_CHK_TOL_EN
      drive(1'b1, 16'd100, 1'b0, 16'd0, 1'b0);
      drive(1'b1, 16'd100, 1'b1, 16'd102, 1'b0);
      drive(1'b0, 16'd0, 1'b1, 16'd103, 1'b1);
      chk("tol_first_act", {16'd0, first_act}, 32'd103);
`else
      drive(1'b1, 16'd100, 1'b0, 16'd0, 1'b0);
      drive(1'b0, 16'd0, 1'b1, 16'd101, 1'b1);
      chk("exact_first_act", {16'd0, first_act}, 32'd101);
`endif
      chk("cmp_mm_cnt", mismatch_cnt, 32'd1);
      pulse(1'b0, 1'b1);
      wait_done(n);
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b1);
      chk("startstop_busy", {31'd0, busy}, 32'd1);
      chk("startstop_ready", {31'd0, exp_ready}, 32'd0);
      chk("startstop_done", {31'd0, done}, 32'd0);
      wait_done(n);
      pulse(1'b1, 1'b0);
      drive(1'b1, 16'd50, 1'b0, 16'd0, 1'b0);
      drive(1'b1, 16'd60, 1'b1, 16'd51, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_ready", {31'd0, exp_ready}, 32'd0);
      chk("mid_rst_mismatch", {31'd0, mismatch}, 32'd0);
      chk("mid_rst_point", point_cnt, 32'd0);
      chk("mid_rst_mm_cnt", mismatch_cnt, 32'd0);
      chk("mid_rst_first_valid", {31'd0, first_valid}, 32'd0);
      chk("mid_rst_first_exp", {16'd0, first_exp}, 32'd0);
      chk("mid_rst_first_act", {16'd0, first_act}, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
